// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: FSM states, standard
// mode constants and total-length helpers.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vt_state_t;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BACK   = 23;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, data enable, coordinates and a lead-adjusted
// pixel request, with run/stop control that only lands on frame boundaries.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int REQ_LEAD = 2,
  parameter int CW       = 12
) (
  input  logic          clock_pixel,
  input  logic          reset,
  input  logic          iEnable,
  output logic          oRunning,
  output logic          oDE,
  output logic          SYNC_H,
  output logic          SYNC_V,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oRequest,
  output logic          oLineStart,
  output logic          oFrameStart
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_STOP = CW'(V_TOTAL - 2);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW:0]   LEAD   = (CW+1)'(REQ_LEAD);
  localparam logic [CW:0]   H_TOTX = (CW+1)'(H_TOTAL);

  vt_state_t     state;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          frame_done;

  logic          active_p0;
  logic          hsync_p0;
  logic          vsync_p0;
  logic          req_p0;
  logic [CW:0]   h_lead;
  logic [CW-1:0] h_req;
  logic [CW-1:0] v_req;

  // Last blanking pixel before the final line: stopping here leaves the
  // counters exactly at the idle position and issues no next-frame request.
  assign frame_done = (hcnt == H_LAST) && (vcnt == V_STOP);

  // p0: decode of the current counter position
  always_comb begin
    active_p0 = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsync_p0  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vsync_p0  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    h_lead    = {1'b0, hcnt} + LEAD;
    h_req     = h_lead[CW-1:0];
    v_req     = vcnt;
    if (h_lead >= H_TOTX) begin
      h_req = CW'(h_lead - H_TOTX);
      v_req = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end
    req_p0    = (h_req < H_ACT) && (v_req < V_ACT);
  end

  // p1: registered state, counters and outputs
  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hcnt        <= '0;
      vcnt        <= V_LAST;
      oRunning    <= 1'b0;
      oDE         <= 1'b0;
      SYNC_H      <= ~H_POL;
      SYNC_V      <= ~V_POL;
      oX          <= '0;
      oY          <= '0;
      oRequest    <= 1'b0;
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          oRunning <= iEnable;
          if (iEnable) state <= ST_RUN;
        end
        ST_RUN: begin
          oRunning <= 1'b1;
          if (!iEnable) state <= ST_STOPPING;
        end
        ST_STOPPING: begin
          oRunning <= iEnable || !frame_done;
          if (iEnable) state <= ST_RUN;
          else if (frame_done) state <= ST_IDLE;
        end
        default: begin
          oRunning <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase

      if (state != ST_IDLE) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end

      if (state == ST_IDLE) begin
        oDE         <= 1'b0;
        SYNC_H      <= ~H_POL;
        SYNC_V      <= ~V_POL;
        oX          <= '0;
        oY          <= '0;
        oRequest    <= 1'b0;
        oLineStart  <= 1'b0;
        oFrameStart <= 1'b0;
      end else begin
        oDE         <= active_p0;
        SYNC_H      <= hsync_p0 ? H_POL : ~H_POL;
        SYNC_V      <= vsync_p0 ? V_POL : ~V_POL;
        oX          <= active_p0 ? hcnt : '0;
        oY          <= active_p0 ? vcnt : '0;
        oRequest    <= req_p0;
        oLineStart  <= active_p0 && (hcnt == '0);
        oFrameStart <= active_p0 && (hcnt == '0) && (vcnt == '0);
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/DVI output path. It produces sync, data-enable, pixel coordinates and a lead-adjustable pixel request from one pixel clock. It adds run/stop control that only takes effect on frame boundaries. It sits between the pixel source, which answers `oRequest`, and the three TMDS encoders and serialiser, which consume `oDE`, `SYNC_H` and `SYNC_V`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines. Must be ≥ 2.
- `H_POL`, 0: asserted level of `SYNC_H` (0 = active-low).
- `V_POL`, 0: asserted level of `SYNC_V`.
- `REQ_LEAD`, 2: number of cycles `oRequest` leads `oDE`. Range 0..H_TOTAL−H_ACTIVE.
- `CW`, 12: counter and coordinate width. Must be ≥ clog2(max(H_TOTAL, V_TOTAL)).

Ports:
- `clock_pixel` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high reset.
- `iEnable` in 1: run request, level-sensitive.
- `oRunning` out 1: high in RUN or STOPPING.
- `oDE` out 1: active-pixel data enable.
- `SYNC_H` out 1: horizontal sync, polarity set by `H_POL`.
- `SYNC_V` out 1: vertical sync, polarity set by `V_POL`.
- `oX` out CW: pixel column while `oDE`=1, else 0.
- `oY` out CW: pixel row while `oDE`=1, else 0.
- `oRequest` out 1: fetch request for the pixel presented `REQ_LEAD` cycles later.
- `oLineStart` out 1: one-cycle pulse with each `oDE` cycle where `oX`=0.
- `oFrameStart` out 1: one-cycle pulse with the `oDE` cycle where `oX`=0 and `oY`=0.

## Operation
- H_TOTAL = sum of the four H parameters (800 by default). V_TOTAL = sum of the four V parameters (525 by default).
- Internal counters `hcnt` (0..H_TOTAL−1) and `vcnt` (0..V_TOTAL−1). `vcnt` advances when `hcnt` wraps from H_TOTAL−1 to 0; `vcnt` wraps from V_TOTAL−1 to 0.
- Active region: `hcnt` < H_ACTIVE and `vcnt` < V_ACTIVE.
- H sync region: H_ACTIVE+H_FRONT ≤ `hcnt` < H_ACTIVE+H_FRONT+H_SYNC. The V sync region is defined the same way on `vcnt`.
- States:
  - IDLE: counters held.
  - RUN.
  - STOPPING: counters run, a stop is pending.
- State transitions:
  - IDLE with `iEnable`=1 → RUN. On that edge `hcnt` is loaded with 0 and `vcnt` with V_TOTAL−1, so a full blanking line precedes the first active pixel.
  - RUN with `iEnable`=0 → STOPPING.
  - STOPPING with `iEnable`=1 → RUN. The stop is cancelled and there is no glitch in the timing.
  - STOPPING at `hcnt`=H_TOTAL−1 and `vcnt`=V_TOTAL−2 → IDLE. The frame completes and no request for the next frame is issued.
- `oRequest` is high exactly when `oDE` will be high REQ_LEAD cycles later. The lead wraps across line and frame boundaries, so requests for line 0 fall in the blanking of line V_TOTAL−1.
- Idle and reset output values:
  - `oDE`, `oRequest`, `oLineStart`, `oFrameStart`, `oRunning` = 0.
  - `oX` = `oY` = 0.
  - `SYNC_H` = ~H_POL, `SYNC_V` = ~V_POL.
  - Counters = (0, V_TOTAL−1), state IDLE.
- `reset` asserted mid-frame forces all outputs to their idle values immediately (asynchronously). After release, the block needs a fresh `iEnable` sample to start.

## Timing
- All outputs are registered. Each output reflects the counter position of the previous cycle, giving a fixed one-cycle pipeline.
- Start-up sequence, where E0 is the edge that samples `iEnable`=1 in IDLE:
  - `oRunning` = 1 after E0.
  - Counters reach (0, 0) at E0+H_TOTAL.
  - `oDE`, `oFrameStart` and `oLineStart` go high after E0+H_TOTAL+1.
  - `oRequest` goes high after E0+H_TOTAL+1−REQ_LEAD.
- `SYNC_H` and `oDE` never both show asserted in the same cycle. `SYNC_V` changes only on the cycle after an `hcnt` wrap.
- `oRunning` falls on the cycle after the STOPPING → IDLE transition. All other outputs are already at their idle levels by then.

## Structure
- Shared package `video_timing_pkg` holds:
  - the state enum (IDLE, RUN, STOPPING);
  - default 640x480@60 constants;
  - an 800x600 constant set;
  - H_TOTAL/V_TOTAL helper functions.
- Single module. No sub-module is warranted: both counters and all decode logic share one state machine.

## Test plan
- Defaults, `iEnable` high from cycle 0:
  - first `oDE`/`oFrameStart` after edge 801;
  - `oRequest` first high after edge 799;
  - 640 `oDE` cycles per line;
  - 480 active lines;
  - frame period 420000 cycles.
- Sync check: `SYNC_H` low for 96 cycles, starting 16 cycles after the last `oDE` of each line. `SYNC_V` low for 2 lines starting at line 490. Repeat with `H_POL`=`V_POL`=1 and confirm the levels invert.
- Drop `iEnable` at line 100: the frame completes through line 523, then IDLE and `oRunning`=0. Count = 480 active lines, and there is no `oRequest` after the last pixel of line 479.
- Drop `iEnable` at line 200, then raise it at line 300: the timing is identical to uninterrupted running and `oRunning` stays 1.
- `REQ_LEAD`=0 and `REQ_LEAD`=160: the `oRequest` pattern equals `oDE` shifted by the lead, including across the line 479→480 and 524→0 wraps.
- Assert `reset` at pixel (320, 240) for 1 cycle:
  - outputs are at idle values before the next edge;
  - restart with `iEnable` gives first `oDE` 801 edges after the start edge.
